// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter
//
// Shares one parity-check engine among NREQ requesters. A round-robin
// arbiter picks one requester at a time and checks its data word against
// the requested parity mode. The pass/fail result goes out on a valid/ready
// response channel, tagged with the requester ID. Failed checks that are
// delivered are counted in a saturating status counter.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-low reset
//   req_valid  per-requester request valid            [NREQ]
//   req_ready  per-requester accept, one-hot or zero  [NREQ]
//   req_data   packed data words, requester i at [i*DW +: DW]
//   req_mode   per-requester parity mode, 0 = even, 1 = odd
//   rsp_valid  result available
//   rsp_ready  consumer accepts the result
//   rsp_id     requester that owns the result         [IDW]
//   rsp_ok     1 when the word's parity matches its mode
//   err_clr    synchronous clear of err_count (wins over an increment)
//   err_count  saturating count of delivered failing results [CNT_W]
//   busy       high whenever a transaction is in flight

module parity_check_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 3,
  parameter int CNT_W = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_ok,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     err_count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    RESP  = 2'b10
  } state_t;

  state_t          state;
  logic [IDW-1:0]  last_id;
  logic [DW-1:0]   cap_data;
  logic            cap_mode;
  logic [IDW-1:0]  cap_id;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [DW-1:0]   win_data;
  logic            win_mode;
  logic            accept;
  logic            rsp_fire;
  int              cand;

  // Round-robin search starting just after the last served requester.
  // The modulo keeps the wrap correct when NREQ is not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_id) + k) % NREQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = IDW'(cand);
      end
    end
  end

  // Select the winner's word and mode for capture.
  always_comb begin
    win_data = req_data[int'(win_id)*DW +: DW];
    win_mode = req_mode[win_id];
  end

  // Grant only in IDLE and only outside reset, so a requester never sees
  // ready during the reset cycle even though the state is still old.
  assign accept    = (state == IDLE) && rst && win_found;
  assign req_ready = accept ? (NREQ'(1) << win_id) : '0;
  assign rsp_fire  = (state == RESP) && rsp_ready;
  assign busy      = (state != IDLE);

  // Transaction FSM: capture in IDLE, evaluate parity in CHECK, then hold
  // the result in RESP until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_id   <= IDW'(NREQ - 1);
      cap_data  <= '0;
      cap_mode  <= 1'b0;
      cap_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_ok    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_data <= win_data;
            cap_mode <= win_mode;
            cap_id   <= win_id;
            state    <= CHECK;
          end
        end
        CHECK: begin
          // XOR-reduce is 1 for an odd number of ones, which is exactly
          // what odd mode expects.
          rsp_ok    <= ((^cap_data) == cap_mode);
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last_id   <= rsp_id;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Failure counter: counts only delivered failing results, sticks at the
  // maximum, and a clear in the same cycle as an increment wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (rsp_fire && !rsp_ok && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_check_arbiter.sv
// tb_parity_check_arbiter
//
// Directed bench for parity_check_arbiter. A behavioural model predicts all
// outputs every cycle; directed sequences add literal expectations for
// grant order, parity results, backpressure, counter edges and mid-flight
// reset. A second instance with a 2-bit counter exercises saturation.

module tb_parity_check_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 3;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_mode;
  logic              rsp_ready;
  logic              err_clr;

  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ok;
  logic [7:0]        err_count;
  logic              busy;

  logic [NREQ-1:0]   req_ready_b;
  logic              rsp_valid_b;
  logic [IDW-1:0]    rsp_id_b;
  logic              rsp_ok_b;
  logic [1:0]        err_count_b;
  logic              busy_b;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cycle_cnt  = 0;

  parity_check_arbiter #(.NREQ(NREQ), .DW(DW), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_ok(rsp_ok),
    .err_clr(err_clr), .err_count(err_count), .busy(busy)
  );

  parity_check_arbiter #(.NREQ(NREQ), .DW(DW), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_b),
    .req_data(req_data), .req_mode(req_mode),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_b), .rsp_ok(rsp_ok_b),
    .err_clr(err_clr), .err_count(err_count_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_cnt++;
    if (actual !== expected) begin
      errors_cnt++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d",
               name, actual, expected, cycle_cnt);
    end
  endtask

  // Behavioural model: a transaction moves idle -> checking -> responding.
  bit          m_init = 1'b0;
  int          m_phase;
  int          m_last;
  int          m_id;
  logic [DW-1:0] m_data;
  logic        m_mode;
  logic        m_rsp_valid;
  int          m_rsp_id;
  logic        m_rsp_ok;
  int          m_cnt8;
  int          m_cnt2;

  function automatic int model_winner(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    cycle_cnt++;
    if (!rst) begin
      m_init      = 1'b1;
      m_phase     = 0;
      m_last      = NREQ - 1;
      m_rsp_valid = 1'b0;
      m_rsp_id    = 0;
      m_rsp_ok    = 1'b0;
      m_cnt8      = 0;
      m_cnt2      = 0;
    end else if (m_init) begin
      case (m_phase)
        0: begin
          w = model_winner(req_valid, m_last);
          if (w >= 0) begin
            m_id    = w;
            m_data  = req_data[w*DW +: DW];
            m_mode  = req_mode[w];
            m_phase = 1;
          end
        end
        1: begin
          m_rsp_ok    = (($countones(m_data) % 2) == int'(m_mode));
          m_rsp_id    = m_id;
          m_rsp_valid = 1'b1;
          m_phase     = 2;
        end
        default: begin
          if (rsp_ready) begin
            m_last = m_rsp_id;
            if (!m_rsp_ok) begin
              if (m_cnt8 < 255) m_cnt8++;
              if (m_cnt2 < 3) m_cnt2++;
            end
            m_rsp_valid = 1'b0;
            m_phase     = 0;
          end
        end
      endcase
      if (err_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int w;
    if (m_init) begin
      exp_ready = '0;
      if (rst && m_phase == 0) begin
        w = model_winner(req_valid, m_last);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      checkOutput("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
      checkOutput("rsp_ok", 32'(rsp_ok), 32'(m_rsp_ok));
      checkOutput("err_count", 32'(err_count), 32'(m_cnt8));
      checkOutput("busy", 32'(busy), 32'(m_phase != 0));
      checkOutput("sat_req_ready", 32'(req_ready_b), 32'(exp_ready));
      checkOutput("sat_rsp_valid", 32'(rsp_valid_b), 32'(m_rsp_valid));
      checkOutput("sat_rsp_id", 32'(rsp_id_b), 32'(m_rsp_id));
      checkOutput("sat_rsp_ok", 32'(rsp_ok_b), 32'(m_rsp_ok));
      checkOutput("sat_err_count", 32'(err_count_b), 32'(m_cnt2));
      checkOutput("sat_busy", 32'(busy_b), 32'(m_phase != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                               input logic [NREQ-1:0] m, input logic rdy, input logic clr);
    req_valid = v;
    req_data  = d;
    req_mode  = m;
    rsp_ready = rdy;
    err_clr   = clr;
  endtask

  task automatic wait_accept(input int id);
    bit acc;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      if (req_ready[id]) acc = 1'b1;
    end
    checkOutput("accept_seen", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(output logic [IDW-1:0] got_id, output logic got_ok);
    bit seen;
    seen   = 1'b0;
    got_id = '0;
    got_ok = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        seen   = 1'b1;
        got_id = rsp_id;
        got_ok = rsp_ok;
      end
    end
    checkOutput("response_seen", 32'(seen), 32'd1);
    tick();
  endtask

  task automatic do_request(input int id, input logic [DW-1:0] d, input logic m,
                            output logic [IDW-1:0] got_id, output logic got_ok);
    req_valid[id]          = 1'b1;
    req_data[id*DW +: DW]  = d;
    req_mode[id]           = m;
    wait_accept(id);
    tick();
    req_valid[id] = 1'b0;
    wait_rsp(got_id, got_ok);
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle_cnt);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [IDW-1:0] gid;
    logic           gok;
    int             hs_id[5];
    int             hs_cyc[5];
    int             exp_order[5];
    int             n_hs;
    bit             seen;

    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b0;
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    repeat (2) tick();

    // Reset must mask grants even with every requester valid.
    req_valid = 4'hF;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();

    $display("[TB] reset priority sequence");
    applyStimulus(4'hF, {3'b011, 3'b010, 3'b001, 3'b000}, 4'h0, 1'b1, 1'b0);
    n_hs = 0;
    for (int c = 0; c < 40 && n_hs < 5; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        hs_id[n_hs]  = int'(rsp_id);
        hs_cyc[n_hs] = cycle_cnt;
        n_hs++;
      end
    end
    checkOutput("prio_count", 32'(n_hs), 32'd5);
    for (int i = 0; i < 5; i++) checkOutput("prio_id", 32'(hs_id[i]), 32'(exp_order[i]));
    for (int i = 1; i < 5; i++) checkOutput("prio_interval", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
    tick();
    req_valid = '0;
    @(negedge clk);
    checkOutput("prio_err_count", 32'(err_count), 32'd2);
    tick();
    pulse_clear();

    $display("[TB] parity function on requester 2");
    do_request(2, 3'b101, 1'b0, gid, gok);
    checkOutput("par_101_e_id", 32'(gid), 32'd2);
    checkOutput("par_101_e_ok", 32'(gok), 32'd1);
    do_request(2, 3'b111, 1'b0, gid, gok);
    checkOutput("par_111_e_ok", 32'(gok), 32'd0);
    do_request(2, 3'b111, 1'b1, gid, gok);
    checkOutput("par_111_o_ok", 32'(gok), 32'd1);
    do_request(2, 3'b000, 1'b1, gid, gok);
    checkOutput("par_000_o_ok", 32'(gok), 32'd0);
    @(negedge clk);
    checkOutput("par_err_count", 32'(err_count), 32'd2);
    checkOutput("par_err_count_sat", 32'(err_count_b), 32'd2);
    tick();

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    req_valid[1] = 1'b1;
    req_data[1*DW +: DW] = 3'b011;
    req_mode[1] = 1'b0;
    wait_accept(1);
    tick();
    req_valid[1] = 1'b0;
    req_valid[3] = 1'b1;
    req_data[3*DW +: DW] = 3'b100;
    req_mode[3] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("bp_rsp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_rsp_ok", 32'(rsp_ok), 32'd1);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    checkOutput("bp_idle_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_idle_busy", 32'(busy), 32'd0);
    checkOutput("bp_idle_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid[3] = 1'b0;
    wait_rsp(gid, gok);
    checkOutput("bp_next_id", 32'(gid), 32'd3);
    checkOutput("bp_next_ok", 32'(gok), 32'd1);

    $display("[TB] counter saturation and clear priority");
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      do_request(0, 3'b001, 1'b0, gid, gok);
      checkOutput("cnt_fail_ok", 32'(gok), 32'd0);
    end
    @(negedge clk);
    checkOutput("cnt_err8", 32'(err_count), 32'd5);
    checkOutput("cnt_err2_sat", 32'(err_count_b), 32'd3);
    tick();
    rsp_ready = 1'b0;
    req_valid[0] = 1'b1;
    wait_accept(0);
    tick();
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("clr_rsp_seen", 32'(seen), 32'd1);
    tick();
    rsp_ready = 1'b1;
    err_clr   = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_wins_err8", 32'(err_count), 32'd0);
    checkOutput("clr_wins_err2", 32'(err_count_b), 32'd0);
    checkOutput("clr_wins_valid", 32'(rsp_valid), 32'd0);
    tick();

    $display("[TB] reset mid-flight");
    do_request(1, 3'b110, 1'b1, gid, gok);
    checkOutput("mid_pre_ok", 32'(gok), 32'd0);
    req_data[0*DW +: DW] = 3'b000;
    req_mode[0] = 1'b0;
    req_data[2*DW +: DW] = 3'b001;
    req_mode[2] = 1'b0;
    req_valid = 4'b0101;
    @(negedge clk);
    checkOutput("mid_grant", 32'(req_ready), 32'h4);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_check_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_err_count", 32'(err_count), 32'd0);
    checkOutput("mid_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    wait_rsp(gid, gok);
    checkOutput("mid_after_id", 32'(gid), 32'd0);
    checkOutput("mid_after_ok", 32'(gok), 32'd1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
